// File: rtl/eth_tx_pkg.sv
`timescale 1ns/1ps
// eth_tx_pkg
// Shared types and constants for the Ethernet frame transmitter:
//   HDR_BYTES  - fixed Ethernet header length (dest MAC, src MAC, EtherType)
//   byte_t     - 8-bit stream byte
//   state_t    - transmitter FSM states
//   idx_t      - header byte index, LAST_IDX = final header byte
package eth_tx_pkg;
  localparam int HDR_BYTES = 14;
  localparam int IDX_W     = $clog2(HDR_BYTES);

  typedef logic [7:0]       byte_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(HDR_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;
endpackage

// File: rtl/eth_hdr_shreg.sv
`timescale 1ns/1ps
// eth_hdr_shreg
// 14-byte header holding register with a byte index. Loads all header
// fields at once, then presents one byte at a time in wire order.
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   load_i                 - capture header fields, index back to 0
//   adv_i                  - current byte consumed, step the index
//   dest_mac_i/src_mac_i/type_i - header fields
//   byte_o                 - header byte at the current index
//   last_o                 - index points at the final header byte
module eth_hdr_shreg
  import eth_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [47:0] dest_mac_i,
  input  logic [47:0] src_mac_i,
  input  logic [15:0] type_i,
  output byte_t       byte_o,
  output logic        last_o
);
  // Concatenation puts dest_mac[47:40] in element HDR_BYTES-1, so wire
  // byte n lives in element LAST_IDX-n.
  logic [HDR_BYTES-1:0][7:0] hdr_q, hdr_d;
  idx_t                      idx_q;

  assign hdr_d = {dest_mac_i, src_mac_i, type_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hdr_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      hdr_q <= hdr_d;
      idx_q <= '0;
    end else if (adv_i && idx_q != LAST_IDX) begin
      idx_q <= idx_q + idx_t'(1);
    end
  end

  assign byte_o = hdr_q[LAST_IDX - idx_q];
  assign last_o = (idx_q == LAST_IDX);
endmodule

// File: rtl/eth_frame_tx.sv
`timescale 1ns/1ps
// eth_frame_tx
// Serializes a 14-byte Ethernet header followed by a payload stream onto
// a single 8-bit AXI-Stream output.
//   clk, rst (sync, active-low)
//   s_eth_hdr_*            - header handshake and fields (dest, src, type)
//   s_eth_payload_axis_*   - payload byte stream in
//   m_axis_*               - serialized frame stream out
//   busy                   - frame in progress
// All outputs are forced to 0 while rst is low, so a reset mid-frame
// never leaks a partial beat or a tlast.
module eth_frame_tx
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy
);
  state_t state_q;
  byte_t  hdr_byte;
  logic   hdr_last;
  logic   hdr_load;
  logic   hdr_adv;

  assign hdr_load = s_eth_hdr_valid && s_eth_hdr_ready;
  assign hdr_adv  = (state_q == HEADER) && m_axis_tready;

  eth_hdr_shreg u_hdr (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (hdr_load),
    .adv_i      (hdr_adv),
    .dest_mac_i (s_eth_dest_mac),
    .src_mac_i  (s_eth_src_mac),
    .type_i     (s_eth_type),
    .byte_o     (hdr_byte),
    .last_o     (hdr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (s_eth_hdr_valid) state_q <= HEADER;
        HEADER:  if (m_axis_tready && hdr_last) state_q <= PAYLOAD;
        PAYLOAD: if (s_eth_payload_axis_tvalid && m_axis_tready &&
                     s_eth_payload_axis_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    m_axis_tdata              = '0;
    m_axis_tvalid             = 1'b0;
    m_axis_tlast              = 1'b0;
    m_axis_tuser              = 1'b0;
    busy                      = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE:    s_eth_hdr_ready = 1'b1;
        HEADER: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = hdr_byte;
          busy          = 1'b1;
        end
        PAYLOAD: begin
          // Payload is a straight wire-through; only one path is live at
          // a time, so upstream bytes are held off during the header.
          m_axis_tvalid             = s_eth_payload_axis_tvalid;
          m_axis_tdata              = s_eth_payload_axis_tdata;
          m_axis_tlast              = s_eth_payload_axis_tlast;
          m_axis_tuser              = s_eth_payload_axis_tuser;
          s_eth_payload_axis_tready = m_axis_tready;
          busy                      = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_frame_tx.sv
`timescale 1ns/1ps
module tb_eth_frame_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_eth_hdr_valid, s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac, s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid, s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast, s_eth_payload_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic        busy;

  eth_frame_tx dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac),
    .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
    logic       h;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cyc[$];
  int    beat_cyc[$];
  bit    busy_log[int];
  int    cyc = 0;
  int    beats = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  beat_t mon_e;

  localparam logic [47:0] DA = 48'h0A0B0C0D0E0F, SA = 48'h112233445566;
  localparam logic [15:0] TA = 16'h0800;
  localparam logic [47:0] DB = 48'h010203040506, SB = 48'h0708090A0B0C;
  localparam logic [15:0] TB = 16'h86DD;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic exp_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    logic [111:0] hv;
    hv = {d, s, t};
    for (int i = 0; i < 14; i++) exp_q.push_back('{d: hv[111-8*i -: 8], l: 1'b0, u: 1'b0, h: 1'b1});
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back('{d: d, l: l, u: u, h: 1'b0});
  endtask

  // Offer a header until accepted, then scramble the fields to prove they were latched.
  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    s_eth_dest_mac = d; s_eth_src_mac = s; s_eth_type = t; s_eth_hdr_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_eth_hdr_ready) begin
        @(posedge clk); #1;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = ~d; s_eth_src_mac = ~s; s_eth_type = ~t;
        return;
      end
    end
    s_eth_hdr_valid = 1'b0;
    n_checks++; n_errors++;
    $display("FAIL hdr_handshake_timeout: got no ready, expected ready within 300 cycles");
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    s_eth_payload_axis_tdata = d; s_eth_payload_axis_tlast = l;
    s_eth_payload_axis_tuser = u; s_eth_payload_axis_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_eth_payload_axis_tready) begin
        @(posedge clk); #1;
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tdata = 8'h00; s_eth_payload_axis_tlast = 1'b0;
        s_eth_payload_axis_tuser = 1'b0;
        return;
      end
    end
    s_eth_payload_axis_tvalid = 1'b0;
    n_checks++; n_errors++;
    $display("FAIL payload_timeout: got no tready, expected tready within 300 cycles");
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares every presented beat against the queue head.
  always @(negedge clk) begin
    busy_log[cyc] = busy;
    if (rst) begin
      if (s_eth_hdr_valid && s_eth_hdr_ready) hs_cyc.push_back(cyc);
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          mon_e = exp_q[0];
          chk("tdata", 64'(m_axis_tdata), 64'(mon_e.d));
          chk("tlast", 64'(m_axis_tlast), 64'(mon_e.l));
          chk("tuser", 64'(m_axis_tuser), 64'(mon_e.u));
          if (mon_e.h) chk("payload_held_in_header", 64'(s_eth_payload_axis_tready), 64'(0));
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            beat_cyc.push_back(cyc);
            beats++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  logic [7:0] t1 [16] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h11, 8'h22,
                          8'h33, 8'h44, 8'h55, 8'h66, 8'h08, 8'h00, 8'hAA, 8'hBB};

  initial begin
    int b, h, t, k;
    rst = 1'b0; s_eth_hdr_valid = 1'b0;
    s_eth_dest_mac = '0; s_eth_src_mac = '0; s_eth_type = '0;
    s_eth_payload_axis_tdata = '0; s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast = 1'b0; s_eth_payload_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hdr_ready", 64'(s_eth_hdr_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_pay_ready", 64'(s_eth_payload_axis_tready), 64'(0));
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("idle_hdr_ready", 64'(s_eth_hdr_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("idle_pay_ready", 64'(s_eth_payload_axis_tready), 64'(0));
    @(posedge clk); #1;

    // Basic frame: hand-listed bytes, 16 consecutive cycles
    b = beat_cyc.size(); h = hs_cyc.size();
    for (int i = 0; i < 16; i++) exp_q.push_back('{d: t1[i], l: (i == 15), u: 1'b0, h: (i < 14)});
    fork
      send_hdr(DA, SA, TA);
      begin send_beat(8'hAA, 1'b0, 1'b0); send_beat(8'hBB, 1'b1, 1'b0); end
    join
    @(negedge clk);
    chk("f1_drained", 64'(exp_q.size()), 64'(0));
    chk("f1_first_latency", 64'(at(beat_cyc, b)), 64'(at(hs_cyc, h) + 1));
    chk("f1_span", 64'(at(beat_cyc, b + 15) - at(beat_cyc, b)), 64'(15));
    @(posedge clk); #1;

    // Stall on header byte 5 for 3 cycles
    b = beat_cyc.size();
    exp_hdr(DA, SA, TA); exp_beat(8'hAA, 1'b0, 1'b0); exp_beat(8'hBB, 1'b1, 1'b0);
    fork
      send_hdr(DA, SA, TA);
      begin send_beat(8'hAA, 1'b0, 1'b0); send_beat(8'hBB, 1'b1, 1'b0); end
      begin
        k = 0;
        while (!(m_axis_tvalid && m_axis_tdata == 8'h0F) && k < 100) begin
          @(posedge clk); #1; k++;
        end
        if (k >= 100) begin
          n_checks++; n_errors++;
          $display("FAIL stall_byte5_seen: got no 0x0F, expected 0x0F within 100 cycles");
        end else begin
          m_axis_tready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk("stall_data", 64'(m_axis_tdata), 64'(8'h0F));
            chk("stall_hdr_ready", 64'(s_eth_hdr_ready), 64'(0));
          end
          @(posedge clk); #1; m_axis_tready = 1'b1;
        end
      end
    join
    @(negedge clk);
    chk("f2_drained", 64'(exp_q.size()), 64'(0));
    chk("f2_byte5_hold", 64'(at(beat_cyc, b + 5) - at(beat_cyc, b + 4)), 64'(4));
    chk("f2_beats", 64'(beat_cyc.size() - b), 64'(16));
    @(posedge clk); #1;

    // Payload offered before the header is held until byte 13 goes out
    b = beat_cyc.size();
    exp_hdr(DA, SA, TA); exp_beat(8'h55, 1'b1, 1'b0);
    fork
      send_beat(8'h55, 1'b1, 1'b0);
      begin
        @(negedge clk);
        chk("early_pay_held", 64'(s_eth_payload_axis_tready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        send_hdr(DA, SA, TA);
      end
    join
    @(negedge clk);
    chk("f3_drained", 64'(exp_q.size()), 64'(0));
    chk("f3_pay_follows", 64'(at(beat_cyc, b + 14) - at(beat_cyc, b + 13)), 64'(1));
    chk("f3_beats", 64'(beat_cyc.size() - b), 64'(15));
    @(posedge clk); #1;

    // Back-to-back frames
    b = beat_cyc.size(); h = hs_cyc.size();
    exp_hdr(DA, SA, TA); exp_beat(8'hAA, 1'b0, 1'b0); exp_beat(8'hBB, 1'b1, 1'b0);
    exp_hdr(DB, SB, TB); exp_beat(8'h01, 1'b0, 1'b1); exp_beat(8'h02, 1'b1, 1'b1);
    fork
      begin send_hdr(DA, SA, TA); send_hdr(DB, SB, TB); end
      begin
        send_beat(8'hAA, 1'b0, 1'b0); send_beat(8'hBB, 1'b1, 1'b0);
        send_beat(8'h01, 1'b0, 1'b1); send_beat(8'h02, 1'b1, 1'b1);
      end
    join
    @(negedge clk);
    t = at(beat_cyc, b + 15);
    chk("b2b_drained", 64'(exp_q.size()), 64'(0));
    chk("b2b_second_hs", 64'(at(hs_cyc, h + 1)), 64'(t + 1));
    chk("b2b_busy_on_tlast", 64'(busy_log[t]), 64'(1));
    chk("b2b_busy_gap", 64'(busy_log[t + 1]), 64'(0));
    chk("b2b_busy_resume", 64'(busy_log[t + 2]), 64'(1));
    @(posedge clk); #1;

    // Reset with header index at 7
    b = beats;
    exp_hdr(DB, SB, TB);
    send_hdr(DB, SB, TB);
    k = 0;
    while (beats < b + 7 && k < 100) begin @(posedge clk); #1; k++; end
    chk("mid_reset_reached_idx7", 64'(beats - b), 64'(7));
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("mrst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("mrst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("mrst_tuser", 64'(m_axis_tuser), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_hdr_ready", 64'(s_eth_hdr_ready), 64'(0));
    chk("mrst_pay_ready", 64'(s_eth_payload_axis_tready), 64'(0));
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_hdr_ready", 64'(s_eth_hdr_ready), 64'(1));
    chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    @(posedge clk); #1;

    // Single-beat payload with tuser, starting fresh after reset
    b = beat_cyc.size();
    exp_hdr(DA, SA, TA); exp_beat(8'h99, 1'b1, 1'b1);
    fork
      send_hdr(DA, SA, TA);
      send_beat(8'h99, 1'b1, 1'b1);
    join
    @(negedge clk);
    chk("f6_drained", 64'(exp_q.size()), 64'(0));
    chk("f6_beats", 64'(beat_cyc.size() - b), 64'(15));
    chk("f6_idle_after", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 Parameters: none; byte width fixed at 8, header length fixed at 14 bytes.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-004 s_eth_hdr_valid  in  1  header offered by upstream write_header stage.
REQ-005 s_eth_hdr_ready  out  1  header accepted when valid and ready are both 1.
REQ-006 s_eth_dest_mac  in  48  destination MAC.
REQ-007 s_eth_src_mac  in  48  source MAC.
REQ-008 s_eth_type  in  16  EtherType.
REQ-009 s_eth_payload_axis_tdata / tvalid / tlast / tuser  in  8/1/1/1  payload byte stream.
REQ-010 s_eth_payload_axis_tready  out  1  payload beat accepted when tvalid and tready are both 1.
REQ-011 m_axis_tdata / tvalid / tlast / tuser  out  8/1/1/1  serialized frame stream.
REQ-012 m_axis_tready  in  1  downstream backpressure.
REQ-013 busy  out  1  frame in progress.

Function
REQ-014 FSM SHALL have states IDLE, HEADER, PAYLOAD.
REQ-015 IDLE: s_eth_hdr_ready=1, busy=0, m_axis_tvalid=0, s_eth_payload_axis_tready=0.
REQ-016 IDLE, hdr handshake: latch all 14 header bytes and clear byte index to 0; next state HEADER; upstream field changes after the handshake have no effect.
REQ-017 Byte order: bytes 0-5 dest_mac[47:40]..[7:0], bytes 6-11 src_mac[47:40]..[7:0], bytes 12-13 type[15:8], type[7:0].
REQ-018 HEADER: m_axis_tvalid=1, tdata=latched byte[index], tlast=0, tuser=0, s_eth_hdr_ready=0, s_eth_payload_axis_tready=0, busy=1.
REQ-019 HEADER: index increments only on m_axis_tvalid&&m_axis_tready; tdata held stable while stalled.
REQ-020 HEADER: acceptance of byte 13 moves to PAYLOAD; index does not wrap past 13.
REQ-021 PAYLOAD: combinational pass-through: m_axis_tvalid=s tvalid, m_axis_tdata/tlast/tuser = s tdata/tlast/tuser, s tready=m_axis_tready; busy=1; s_eth_hdr_ready=0.
REQ-022 PAYLOAD: accepted beat with tlast=1 moves to IDLE; next header accepted no earlier than the following cycle (one-cycle gap between frames).
REQ-023 Latency: first header byte valid on m_axis the cycle after the hdr handshake; minimum frame = 14 + N cycles for N payload beats with m_axis_tready held 1, plus 1 IDLE cycle.
REQ-024 Payload presented before or during HEADER SHALL be held off (tready=0), never dropped or reordered.
REQ-025 Every frame SHALL contain at least one payload beat; tuser passes through unmodified, including on the tlast beat.

Reset
REQ-026 While rst=0: state forced IDLE, index=0, header register cleared.
REQ-027 While rst=0 all outputs SHALL be 0, including s_eth_hdr_ready; s_eth_hdr_ready rises in the first cycle with rst=1.
REQ-028 Reset during HEADER or PAYLOAD SHALL abandon the frame without emitting tlast; no partial state survives.

Structure
REQ-029 Shared package eth_tx_pkg SHALL hold HDR_BYTES=14, the state enumeration, and the 8-bit byte type.
REQ-030 One sub-module, eth_hdr_shreg (14-byte load/select register with index), is permitted; FSM and muxing live in eth_frame_tx.

Verification
REQ-031 Header dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800, payload 0xAA,0xBB(tlast); m_axis_tready=1 -> m_axis bytes 0A 0B 0C 0D 0E 0F 11 22 33 44 55 66 08 00 AA BB, tlast only on BB, 16 consecutive cycles.
REQ-032 Same frame, m_axis_tready=0 for 3 cycles on byte 5 -> 0F held stable for 4 cycles, no byte skipped or duplicated, s_eth_hdr_ready stays 0.
REQ-033 Payload tvalid=1 with 0x55 asserted from cycle 0 before the header -> s tready=0 until byte 13 (0x00) accepted; 0x55 emitted immediately after, exactly once.
REQ-034 Two back-to-back frames, hdr_valid held 1 -> second hdr handshake exactly one cycle after the first frame's tlast beat; busy drops for exactly that cycle.
REQ-035 rst=0 asserted while index=7 -> next cycle all outputs 0, no tlast emitted; after rst=1 a new frame serializes from byte 0 correctly.
REQ-036 Single-beat payload 0x99 with tlast=1, tuser=1 -> 15-byte frame ending 0x99 with tlast=1, tuser=1; tuser=0 on all header bytes.
